// File: rtl/zcu111_axi_led_regs.sv
// rtl/zcu111_axi_led_regs.sv - AXI4 slave exposing LED, scratch, ID and cycle-counter registers
module zcu111_axi_led_regs #(
  parameter int            ADDR_WIDTH = 40,
  parameter int            ID_WIDTH   = 8,
  parameter logic [7:0]    LED_RESET  = 8'hA5,
  parameter logic [63:0]   BLOCK_ID   = 64'h0000_0000_5A11_0111
) (
  input  logic                  axi_clk,
  input  logic                  axi_rst_n,
  input  logic [ADDR_WIDTH-1:0] s_axi_awaddr,
  input  logic [ID_WIDTH-1:0]   s_axi_awid,
  input  logic [7:0]            s_axi_awlen,
  input  logic [2:0]            s_axi_awsize,
  input  logic [1:0]            s_axi_awburst,
  input  logic                  s_axi_awvalid,
  output logic                  s_axi_awready,
  input  logic [63:0]           s_axi_wdata,
  input  logic [7:0]            s_axi_wstrb,
  input  logic                  s_axi_wlast,
  input  logic                  s_axi_wvalid,
  output logic                  s_axi_wready,
  output logic [ID_WIDTH-1:0]   s_axi_bid,
  output logic [1:0]            s_axi_bresp,
  output logic                  s_axi_bvalid,
  input  logic                  s_axi_bready,
  input  logic [ADDR_WIDTH-1:0] s_axi_araddr,
  input  logic [ID_WIDTH-1:0]   s_axi_arid,
  input  logic [7:0]            s_axi_arlen,
  input  logic [2:0]            s_axi_arsize,
  input  logic [1:0]            s_axi_arburst,
  input  logic                  s_axi_arvalid,
  output logic                  s_axi_arready,
  output logic [63:0]           s_axi_rdata,
  output logic [ID_WIDTH-1:0]   s_axi_rid,
  output logic [1:0]            s_axi_rresp,
  output logic                  s_axi_rlast,
  output logic                  s_axi_rvalid,
  input  logic                  s_axi_rready,
  output logic [7:0]            leds
);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] BURST_FIXED = 2'b00;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic       {R_IDLE, R_DATA} r_state_t;

  // Burst-wide error: only size 3 (8 bytes) and FIXED/INCR bursts are supported
  function automatic logic cfg_error(input logic [2:0] size, input logic [1:0] burst);
    return (size != 3'd3) || burst[1];
  endfunction

  w_state_t w_state_q, w_state_d;
  r_state_t r_state_q, r_state_d;
  logic     ready_en_q;

  logic [7:0]  led_q;
  logic [63:0] scratch_q;
  logic [63:0] cnt_q;

  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [ID_WIDTH-1:0]   wr_id;
  logic [7:0]            wr_len, wr_cnt;
  logic                  wr_fixed, wr_cfg_err, wr_err;
  logic                  wr_last_beat, wr_beat_err;
  logic                  aw_hs, w_hs;

  logic [ADDR_WIDTH-1:0] rd_addr, rd_next_addr, rd_load_addr;
  logic [ID_WIDTH-1:0]   rd_id;
  logic [7:0]            rd_len, rd_cnt;
  logic                  rd_fixed, rd_cfg_err, rd_load_cfg_err, rd_load_err;
  logic                  rd_last_beat, ar_hs, r_hs;
  logic [63:0]           rd_load_data;
  logic                  unused_addr_bits;

  assign aw_hs        = s_axi_awvalid && s_axi_awready;
  assign w_hs         = s_axi_wvalid && s_axi_wready;
  assign ar_hs        = s_axi_arvalid && s_axi_arready;
  assign r_hs         = s_axi_rvalid && s_axi_rready;
  assign wr_last_beat = (wr_cnt == wr_len);
  assign wr_beat_err  = wr_cfg_err || (wr_addr[ADDR_WIDTH-1:5] != '0);
  assign rd_last_beat = (rd_cnt == rd_len);
  assign rd_next_addr = rd_fixed ? rd_addr : rd_addr + ADDR_WIDTH'(8);

  assign s_axi_bid   = wr_id;
  assign s_axi_bresp = wr_err ? RESP_SLVERR : RESP_OKAY;
  assign s_axi_rid   = rd_id;
  assign leds        = led_q;

  // Holds off address acceptance until the first edge after reset release
  always_ff @(posedge axi_clk or negedge axi_rst_n) begin
    if (!axi_rst_n) begin
      ready_en_q <= 1'b0;
      w_state_q  <= W_IDLE;
      r_state_q  <= R_IDLE;
    end else begin
      ready_en_q <= 1'b1;
      w_state_q  <= w_state_d;
      r_state_q  <= r_state_d;
    end
  end

  always_comb begin
    w_state_d     = w_state_q;
    s_axi_awready = 1'b0;
    s_axi_wready  = 1'b0;
    s_axi_bvalid  = 1'b0;
    case (w_state_q)
      W_IDLE: begin
        s_axi_awready = ready_en_q;
        if (s_axi_awvalid && ready_en_q) w_state_d = W_DATA;
      end
      W_DATA: begin
        s_axi_wready = 1'b1;
        if (s_axi_wvalid && wr_last_beat) w_state_d = W_RESP;
      end
      W_RESP: begin
        s_axi_bvalid = 1'b1;
        if (s_axi_bready) w_state_d = W_IDLE;
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  always_comb begin
    r_state_d     = r_state_q;
    s_axi_arready = 1'b0;
    s_axi_rvalid  = 1'b0;
    case (r_state_q)
      R_IDLE: begin
        s_axi_arready = ready_en_q;
        if (s_axi_arvalid && ready_en_q) r_state_d = R_DATA;
      end
      R_DATA: begin
        s_axi_rvalid = 1'b1;
        if (s_axi_rready && rd_last_beat) r_state_d = R_IDLE;
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge axi_clk or negedge axi_rst_n) begin
    if (!axi_rst_n) begin
      wr_addr    <= '0;
      wr_id      <= '0;
      wr_len     <= '0;
      wr_cnt     <= '0;
      wr_fixed   <= 1'b0;
      wr_cfg_err <= 1'b0;
      wr_err     <= 1'b0;
    end else if (aw_hs) begin
      wr_addr    <= s_axi_awaddr;
      wr_id      <= s_axi_awid;
      wr_len     <= s_axi_awlen;
      wr_cnt     <= '0;
      wr_fixed   <= (s_axi_awburst == BURST_FIXED);
      wr_cfg_err <= cfg_error(s_axi_awsize, s_axi_awburst);
      wr_err     <= 1'b0;
    end else if (w_hs) begin
      wr_cnt <= wr_cnt + 8'd1;
      if (!wr_fixed) wr_addr <= wr_addr + ADDR_WIDTH'(8);
      wr_err <= wr_err || wr_beat_err || (s_axi_wlast != wr_last_beat);
    end
  end

  always_ff @(posedge axi_clk or negedge axi_rst_n) begin
    if (!axi_rst_n) begin
      led_q     <= LED_RESET;
      scratch_q <= '0;
      cnt_q     <= '0;
    end else begin
      cnt_q <= cnt_q + 64'd1;
      if (w_hs && !wr_beat_err) begin
        case (wr_addr[4:3])
          2'd0: if (s_axi_wstrb[0]) led_q <= s_axi_wdata[7:0];
          2'd1: begin
            for (int b = 0; b < 8; b++) begin
              if (s_axi_wstrb[b]) scratch_q[b*8 +: 8] <= s_axi_wdata[b*8 +: 8];
            end
          end
          default: ;
        endcase
      end
    end
  end

  // The beat being loaded comes from AR while idle, otherwise from the next burst address
  always_comb begin
    rd_load_addr    = rd_next_addr;
    rd_load_cfg_err = rd_cfg_err;
    if (r_state_q == R_IDLE) begin
      rd_load_addr    = s_axi_araddr;
      rd_load_cfg_err = cfg_error(s_axi_arsize, s_axi_arburst);
    end
    rd_load_err  = rd_load_cfg_err || (rd_load_addr[ADDR_WIDTH-1:5] != '0);
    rd_load_data = '0;
    if (!rd_load_err) begin
      case (rd_load_addr[4:3])
        2'd0:    rd_load_data = {56'd0, led_q};
        2'd1:    rd_load_data = scratch_q;
        2'd2:    rd_load_data = BLOCK_ID;
        default: rd_load_data = cnt_q;
      endcase
    end
  end

  assign unused_addr_bits = ^rd_load_addr[2:0];

  always_ff @(posedge axi_clk or negedge axi_rst_n) begin
    if (!axi_rst_n) begin
      rd_addr     <= '0;
      rd_id       <= '0;
      rd_len      <= '0;
      rd_cnt      <= '0;
      rd_fixed    <= 1'b0;
      rd_cfg_err  <= 1'b0;
      s_axi_rdata <= '0;
      s_axi_rresp <= RESP_OKAY;
      s_axi_rlast <= 1'b0;
    end else if (ar_hs) begin
      rd_addr     <= s_axi_araddr;
      rd_id       <= s_axi_arid;
      rd_len      <= s_axi_arlen;
      rd_cnt      <= '0;
      rd_fixed    <= (s_axi_arburst == BURST_FIXED);
      rd_cfg_err  <= rd_load_cfg_err;
      s_axi_rdata <= rd_load_data;
      s_axi_rresp <= rd_load_err ? RESP_SLVERR : RESP_OKAY;
      s_axi_rlast <= (s_axi_arlen == 8'd0);
    end else if (r_hs) begin
      if (rd_last_beat) begin
        s_axi_rlast <= 1'b0;
      end else begin
        rd_addr     <= rd_next_addr;
        rd_cnt      <= rd_cnt + 8'd1;
        s_axi_rdata <= rd_load_data;
        s_axi_rresp <= rd_load_err ? RESP_SLVERR : RESP_OKAY;
        s_axi_rlast <= (rd_cnt + 8'd1 == rd_len);
      end
    end
  end

endmodule

// File: tb/tb_zcu111_axi_led_regs.sv
// tb/tb_zcu111_axi_led_regs.sv - self-checking bench for zcu111_axi_led_regs
module tb_zcu111_axi_led_regs;

  localparam int AW = 40;
  localparam logic [63:0] BLOCK_ID = 64'h0000_0000_5A11_0111;

  logic          clk, rst_n;
  logic [AW-1:0] awaddr, araddr;
  logic [7:0]    awid, awlen, arid, arlen, wstrb, bid, rid, leds;
  logic [2:0]    awsize, arsize;
  logic [1:0]    awburst, arburst, bresp, rresp;
  logic          awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic          arvalid, arready, rlast, rvalid, rready;
  logic [63:0]   wdata, rdata;

  zcu111_axi_led_regs dut (
    .axi_clk(clk), .axi_rst_n(rst_n),
    .s_axi_awaddr(awaddr), .s_axi_awid(awid), .s_axi_awlen(awlen), .s_axi_awsize(awsize),
    .s_axi_awburst(awburst), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
    .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wlast(wlast), .s_axi_wvalid(wvalid),
    .s_axi_wready(wready), .s_axi_bid(bid), .s_axi_bresp(bresp), .s_axi_bvalid(bvalid),
    .s_axi_bready(bready), .s_axi_araddr(araddr), .s_axi_arid(arid), .s_axi_arlen(arlen),
    .s_axi_arsize(arsize), .s_axi_arburst(arburst), .s_axi_arvalid(arvalid),
    .s_axi_arready(arready), .s_axi_rdata(rdata), .s_axi_rid(rid), .s_axi_rresp(rresp),
    .s_axi_rlast(rlast), .s_axi_rvalid(rvalid), .s_axi_rready(rready), .leds(leds)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycles since reset release: the value CNT must show when a beat is loaded
  logic [63:0] tb_cyc;
  always @(posedge clk or negedge rst_n)
    if (!rst_n) tb_cyc <= '0;
    else        tb_cyc <= tb_cyc + 64'd1;

  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  logic [7:0]  m_led;
  logic [63:0] m_scratch;
  logic [63:0] wbuf [4];

  function automatic logic [AW-1:0] beat_addr(input logic [AW-1:0] a, input logic [1:0] bu, input int i);
    return (bu == 2'b00) ? a : a + AW'(8 * i);
  endfunction

  function automatic bit beat_err(input logic [AW-1:0] a, input logic [2:0] sz, input logic [1:0] bu);
    return ((a >> 5) != 0) || (sz != 3'd3) || (bu >= 2'd2);
  endfunction

  function automatic logic [63:0] m_read(input logic [AW-1:0] a, input bit err, input logic [63:0] stamp);
    int idx;
    idx = int'(a % 32) / 8;
    if (err) return 64'd0;
    case (idx)
      0:       return {56'd0, m_led};
      1:       return m_scratch;
      2:       return BLOCK_ID;
      default: return stamp;
    endcase
  endfunction

  function automatic logic [1:0] m_wr_resp(input logic [AW-1:0] a, input logic [7:0] ln,
                                           input logic [2:0] sz, input logic [1:0] bu);
    for (int i = 0; i <= int'(ln); i++)
      if (beat_err(beat_addr(a, bu, i), sz, bu)) return 2'b10;
    return 2'b00;
  endfunction

  task automatic m_reset();
    m_led = 8'hA5;
    m_scratch = 64'd0;
  endtask

  task automatic do_write(input logic [7:0] id, input logic [AW-1:0] a, input logic [7:0] ln,
                          input logic [2:0] sz, input logic [1:0] bu, input logic [7:0] st,
                          input bit bad_last, input logic [1:0] exp_resp);
    int t;
    logic [AW-1:0] ba;
    @(negedge clk);
    awid = id; awaddr = a; awlen = ln; awsize = sz; awburst = bu; awvalid = 1'b1;
    t = 0;
    while (!awready && t < 100) begin @(negedge clk); t++; end
    if (!awready) begin check("aw_timeout", 1, 0); awvalid = 1'b0; return; end
    @(negedge clk);
    awvalid = 1'b0;
    for (int i = 0; i <= int'(ln); i++) begin
      wvalid = 1'b1; wdata = wbuf[i]; wstrb = st;
      wlast = bad_last ? 1'b0 : (i == int'(ln));
      t = 0;
      while (!wready && t < 100) begin @(negedge clk); t++; end
      if (!wready) begin check("w_timeout", 1, 0); wvalid = 1'b0; return; end
      ba = beat_addr(a, bu, i);
      if (!beat_err(ba, sz, bu)) begin
        if (int'(ba % 32) / 8 == 0 && st[0]) m_led = wbuf[i][7:0];
        if (int'(ba % 32) / 8 == 1)
          for (int b = 0; b < 8; b++) if (st[b]) m_scratch[b*8 +: 8] = wbuf[i][b*8 +: 8];
      end
      @(negedge clk);
    end
    wvalid = 1'b0; wlast = 1'b0;
    check("b_latency", bvalid, 1);
    bready = 1'b1;
    t = 0;
    while (!bvalid && t < 100) begin @(negedge clk); t++; end
    check("bresp", bresp, exp_resp);
    check("bid", bid, id);
    @(negedge clk);
    bready = 1'b0;
    check("leds", leds, m_led);
  endtask

  task automatic do_read(input logic [7:0] id, input logic [AW-1:0] a, input logic [7:0] ln,
                         input logic [2:0] sz, input logic [1:0] bu, input int mode,
                         output logic [63:0] d0, output logic [1:0] r0);
    int t, i;
    bit stalled, err;
    logic [63:0] stamp, hold_d;
    logic hold_l;
    logic [AW-1:0] ba;
    d0 = '0; r0 = '0;
    @(negedge clk);
    arid = id; araddr = a; arlen = ln; arsize = sz; arburst = bu; arvalid = 1'b1;
    t = 0;
    while (!arready && t < 100) begin @(negedge clk); t++; end
    if (!arready) begin check("ar_timeout", 1, 0); arvalid = 1'b0; return; end
    stamp = tb_cyc;
    @(negedge clk);
    arvalid = 1'b0;
    check("r_latency", rvalid, 1);
    i = 0; t = 0; stalled = 0;
    while (i <= int'(ln) && t < 200) begin
      case (mode)
        0:       rready = 1'b1;
        1:       rready = (t % 2 == 0);
        default: rready = 1'($urandom_range(0, 1));
      endcase
      if (rvalid && stalled) begin
        check("r_stable_data", rdata, hold_d);
        check("r_stable_last", rlast, hold_l);
      end
      stalled = rvalid && !rready;
      hold_d = rdata; hold_l = rlast;
      if (rvalid && rready) begin
        ba  = beat_addr(a, bu, i);
        err = beat_err(ba, sz, bu);
        check("rdata", rdata, m_read(ba, err, stamp));
        check("rresp", rresp, err ? 2'b10 : 2'b00);
        check("rlast", rlast, i == int'(ln));
        check("rid", rid, id);
        if (i == 0) begin d0 = rdata; r0 = rresp; end
        stamp = tb_cyc;
        i++;
      end
      @(negedge clk);
      t++;
    end
    rready = 1'b0;
    if (i <= int'(ln)) check("r_timeout", i, int'(ln) + 1);
    else check("r_done", rvalid, 0);
  endtask

  typedef struct {
    bit          wr;
    logic [7:0]  id;
    logic [AW-1:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    logic [63:0] d0, d1;
    logic [7:0]  strb;
    bit          bad_last;
    logic [1:0]  exp_resp;
    logic [63:0] exp_d0;
    logic [7:0]  exp_leds;
  } vec_t;

  vec_t vecs [17];
  logic [63:0] rd0;
  logic [1:0]  rr0;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vecs[0]  = '{0, 8'h01, 40'h10, 0, 3, 1, 0, 0, 0, 0, 2'b00, BLOCK_ID, 8'hA5};
    vecs[1]  = '{1, 8'h5A, 40'h00, 0, 3, 1, 64'h3C, 0, 8'h01, 0, 2'b00, 0, 8'h3C};
    vecs[2]  = '{1, 8'h5A, 40'h00, 0, 3, 1, 64'hFF, 0, 8'h00, 0, 2'b00, 0, 8'h3C};
    vecs[3]  = '{1, 8'h22, 40'h00, 1, 3, 1, 64'h11, 64'hDEAD_BEEF, 8'hFF, 0, 2'b00, 0, 8'h11};
    vecs[4]  = '{0, 8'h33, 40'h08, 0, 3, 1, 0, 0, 0, 0, 2'b00, 64'hDEAD_BEEF, 8'h11};
    vecs[5]  = '{1, 8'h44, 40'h10, 3, 3, 1, 64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0, 8'hFF, 0, 2'b10, 0, 8'h11};
    vecs[6]  = '{0, 8'h45, 40'h08, 0, 3, 1, 0, 0, 0, 0, 2'b00, 64'hDEAD_BEEF, 8'h11};
    vecs[7]  = '{0, 8'h46, 40'h40, 0, 3, 1, 0, 0, 0, 0, 2'b10, 0, 8'h11};
    vecs[8]  = '{0, 8'h47, 40'h00, 0, 2, 1, 0, 0, 0, 0, 2'b10, 0, 8'h11};
    vecs[9]  = '{0, 8'h48, 40'h00, 0, 3, 2, 0, 0, 0, 0, 2'b10, 0, 8'h11};
    vecs[10] = '{1, 8'h49, 40'h08, 1, 3, 0, 64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5555, 8'h0F, 0, 2'b00, 0, 8'h11};
    vecs[11] = '{0, 8'h4A, 40'h0C, 0, 3, 1, 0, 0, 0, 0, 2'b00, 64'h5555_5555, 8'h11};
    vecs[12] = '{1, 8'h4B, 40'h10, 0, 3, 1, 0, 0, 8'hFF, 1, 2'b10, 0, 8'h11};
    vecs[13] = '{0, 8'h4C, 40'h00, 3, 3, 1, 0, 0, 0, 0, 2'b00, 64'h11, 8'h11};
    vecs[14] = '{1, 8'h4D, 40'h00, 0, 2, 1, 64'h99, 0, 8'hFF, 0, 2'b10, 0, 8'h11};
    vecs[15] = '{1, 8'h4E, 40'h18, 0, 3, 1, 0, 0, 8'hFF, 0, 2'b00, 0, 8'h11};
    vecs[16] = '{0, 8'h4F, 40'h10, 0, 3, 1, 0, 0, 0, 0, 2'b00, BLOCK_ID, 8'h11};

    rst_n = 1'b0;
    awaddr = '0; awid = '0; awlen = '0; awsize = '0; awburst = '0; awvalid = 1'b0;
    araddr = '0; arid = '0; arlen = '0; arsize = '0; arburst = '0; arvalid = 1'b0;
    wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0; rready = 1'b0;
    m_reset();
    repeat (3) @(negedge clk);
    check("rst_awready", awready, 0);
    check("rst_arready", arready, 0);
    check("rst_wready", wready, 0);
    check("rst_bvalid", bvalid, 0);
    check("rst_rvalid", rvalid, 0);
    check("rst_rlast", rlast, 0);
    check("rst_rdata", rdata, 0);
    check("rst_bresp", bresp, 0);
    check("rst_rresp", rresp, 0);
    check("rst_leds", leds, 8'hA5);
    rst_n = 1'b1;
    @(negedge clk);
    check("awready_after_rst", awready, 1);
    check("arready_after_rst", arready, 1);

    for (int v = 0; v < 17; v++) begin
      if (vecs[v].wr) begin
        wbuf[0] = vecs[v].d0;
        for (int k = 1; k < 4; k++) wbuf[k] = vecs[v].d1;
        do_write(vecs[v].id, vecs[v].addr, vecs[v].len, vecs[v].size, vecs[v].burst,
                 vecs[v].strb, vecs[v].bad_last, vecs[v].exp_resp);
      end else begin
        do_read(vecs[v].id, vecs[v].addr, vecs[v].len, vecs[v].size, vecs[v].burst, 0, rd0, rr0);
        check("tbl_rdata", rd0, vecs[v].exp_d0);
        check("tbl_rresp", rr0, vecs[v].exp_resp);
      end
      check("tbl_leds", leds, vecs[v].exp_leds);
    end

    // Stalled read with a concurrent LED write on the other channel
    wbuf[0] = 64'h6B;
    fork
      do_write(8'h61, 40'h00, 0, 3, 1, 8'h01, 0, 2'b00);
      do_read(8'h62, 40'h08, 2, 3, 1, 1, rd0, rr0);
    join
    check("conc_leds", leds, 8'h6B);

    // Reset in the middle of a write burst
    @(negedge clk);
    awid = 8'h07; awaddr = 40'h00; awlen = 8'd3; awsize = 3'd3; awburst = 2'b01; awvalid = 1'b1;
    @(negedge clk);
    awvalid = 1'b0;
    wvalid = 1'b1; wdata = 64'h77; wstrb = 8'hFF; wlast = 1'b0;
    check("mid_wready", wready, 1);
    @(negedge clk);
    check("mid_leds", leds, 8'h77);
    rst_n = 1'b0;
    #1;
    check("abort_wready", wready, 0);
    check("abort_bvalid", bvalid, 0);
    check("abort_leds", leds, 8'hA5);
    wvalid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    m_reset();
    repeat (3) @(negedge clk);
    check("abort_no_bvalid", bvalid, 0);
    do_read(8'h70, 40'h08, 0, 3, 1, 0, rd0, rr0);
    check("post_rst_scratch", rd0, 64'd0);
    wbuf[0] = 64'h5E;
    do_write(8'h71, 40'h00, 0, 3, 1, 8'h01, 0, 2'b00);
    check("post_rst_leds", leds, 8'h5E);

    for (int n = 0; n < 40; n++) begin
      logic [AW-1:0] a;
      logic [7:0] ln;
      logic [2:0] sz;
      logic [1:0] bu;
      case ($urandom_range(0, 7))
        0, 1, 2, 3: a = AW'($urandom_range(0, 3) * 8 + $urandom_range(0, 7));
        4:          a = 40'h20;
        5:          a = 40'h40;
        6:          a = 40'h10_0000_0008;
        default:    a = 40'h18;
      endcase
      ln = 8'($urandom_range(0, 3));
      sz = ($urandom_range(0, 4) == 0) ? 3'($urandom_range(0, 7)) : 3'd3;
      bu = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(2, 3)) : 2'($urandom_range(0, 1));
      if ($urandom_range(0, 1) == 1) begin
        for (int k = 0; k < 4; k++) wbuf[k] = {$urandom, $urandom};
        do_write(8'($urandom), a, ln, sz, bu, 8'($urandom), 0, m_wr_resp(a, ln, sz, bu));
      end else begin
        do_read(8'($urandom), a, ln, sz, bu, 2, rd0, rr0);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
